// File: rtl/prog_modulo_counter_if.sv
// Control/status bundle for prog_modulo_counter.
//   master : drives enable, start, oneshot, load, modulo_in; observes status.
//   slave  : the counter; observes controls, drives tick, sq_out, running,
//            count and tick_count.
interface prog_modulo_counter_if #(
    parameter int unsigned BIT_SZ      = 16,
    parameter int unsigned TICK_CNT_SZ = 8
);
    logic                   enable;
    logic                   start;
    logic                   oneshot;
    logic                   load;
    logic [BIT_SZ-1:0]      modulo_in;
    logic                   tick;
    logic                   sq_out;
    logic                   running;
    logic [BIT_SZ-1:0]      count;
    logic [TICK_CNT_SZ-1:0] tick_count;

    modport master (
        output enable, start, oneshot, load, modulo_in,
        input  tick, sq_out, running, count, tick_count
    );

    modport slave (
        input  enable, start, oneshot, load, modulo_in,
        output tick, sq_out, running, count, tick_count
    );
endinterface

// File: rtl/prog_modulo_counter.sv
// Run-time programmable modulo counter / clock divider.
// Emits a one-cycle tick per period of mod_r enabled cycles, a near-50%
// square wave, and a wrapping count of ticks emitted.
// Ports:
//   clock    : system clock, rising edge
//   sreset_n : synchronous active-low reset
//   bus      : prog_modulo_counter_if.slave (controls in, status out)
module prog_modulo_counter #(
    parameter int unsigned BIT_SZ       = 16,
    parameter int unsigned RESET_MODULO = 50000,
    parameter int unsigned TICK_CNT_SZ  = 8
) (
    input logic                     clock,
    input logic                     sreset_n,
    prog_modulo_counter_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [BIT_SZ-1:0] RST_MOD = BIT_SZ'(RESET_MODULO);

    state_t                 r_state;
    logic [BIT_SZ-1:0]      r_mod;
    logic                   r_mode;
    logic [BIT_SZ-1:0]      r_count;
    logic                   r_tick;
    logic                   r_sq;
    logic [TICK_CNT_SZ-1:0] r_tick_count;

    logic                   w_last;
    logic [BIT_SZ-1:0]      w_count_next;
    logic [BIT_SZ:0]        w_half;
    logic                   w_sq_next;
    logic                   w_load_ok;

    // r_mod is never 0, so r_mod-1 cannot underflow.
    assign w_last       = (r_count == (r_mod - BIT_SZ'(1)));
    assign w_count_next = w_last ? '0 : (r_count + BIT_SZ'(1));
    // Half-period threshold, one bit wider so r_mod = all-ones cannot overflow.
    assign w_half       = ({1'b0, r_mod} + (BIT_SZ + 1)'(1)) >> 1;
    assign w_sq_next    = ({1'b0, w_count_next} < w_half);
    // A zero modulo load is treated as if load were not asserted.
    assign w_load_ok    = bus.load && (bus.modulo_in != '0);

    always_ff @(posedge clock) begin
        if (!sreset_n) begin
            r_state      <= IDLE;
            r_mod        <= RST_MOD;
            r_mode       <= 1'b0;
            r_count      <= '0;
            r_tick       <= 1'b0;
            r_sq         <= 1'b0;
            r_tick_count <= '0;
        end else if (w_load_ok) begin
            r_mod        <= bus.modulo_in;
            r_count      <= '0;
            r_tick       <= 1'b0;
            r_tick_count <= '0;
            // Count restarts at 0, which is always in the high half.
            r_sq         <= (r_state == RUN);
        end else if (bus.start) begin
            r_state <= RUN;
            r_count <= '0;
            r_mode  <= bus.oneshot;
            r_tick  <= 1'b0;
            r_sq    <= 1'b1;
        end else begin
            case (r_state)
                RUN: begin
                    if (bus.enable) begin
                        r_count <= w_count_next;
                        r_tick  <= w_last;
                        r_sq    <= w_sq_next;
                        if (w_last) begin
                            r_tick_count <= r_tick_count + TICK_CNT_SZ'(1);
                            if (r_mode) begin
                                r_state <= DONE;
                            end
                        end
                    end else begin
                        r_tick <= 1'b0;
                    end
                end
                default: begin
                    r_tick <= 1'b0;
                    r_sq   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.tick       = r_tick;
    assign bus.sq_out     = r_sq;
    assign bus.running    = (r_state == RUN);
    assign bus.count      = r_count;
    assign bus.tick_count = r_tick_count;
endmodule

// File: tb/tb_prog_modulo_counter.sv
module tb_prog_modulo_counter;
    localparam int unsigned RST_MOD = 20;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    prog_modulo_counter_if #(.BIT_SZ(16), .TICK_CNT_SZ(8)) bus ();

    prog_modulo_counter #(
        .BIT_SZ(16),
        .RESET_MODULO(RST_MOD),
        .TICK_CNT_SZ(8)
    ) dut (
        .clock(clk),
        .sreset_n(rst_n),
        .bus(bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [15:0] v);
        bus.load = 1'b1; bus.modulo_in = v; bus.enable = 1'b0;
        step();
        bus.load = 1'b0;
    endtask

    task automatic do_start(input logic os);
        bus.start = 1'b1; bus.oneshot = os;
        step();
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        n_tests++;
        if ({bus.count, bus.tick, bus.sq_out, bus.running, bus.tick_count} !== 27'd0) begin
            n_fail++;
            $display("FAIL reset: count=%0d tick=%b sq=%b run=%b tcnt=%0d, all required 0",
                     bus.count, bus.tick, bus.sq_out, bus.running, bus.tick_count);
        end
    endtask

    task automatic test_default_modulo();
        do_start(1'b0);
        bus.enable = 1'b1;
        for (int i = 1; i <= 3 * RST_MOD; i++) begin
            step();
            n_tests++;
            if (bus.tick !== ((i % RST_MOD) == 0) || bus.count !== 16'(i % RST_MOD)) begin
                n_fail++;
                $display("FAIL default_mod cyc %0d: tick=%b count=%0d, required tick=%b count=%0d",
                         i, bus.tick, bus.count, (i % RST_MOD) == 0, i % RST_MOD);
            end
        end
        n_tests++;
        if (bus.tick_count !== 8'd3) begin
            n_fail++;
            $display("FAIL default_tcnt: got %0d required 3", bus.tick_count);
        end
    endtask

    task automatic test_periodic();
        do_load(16'd5);
        do_start(1'b0);
        n_tests++;
        if (bus.count !== 16'd0 || bus.sq_out !== 1'b1 || bus.running !== 1'b1) begin
            n_fail++;
            $display("FAIL periodic_start: count=%0d sq=%b run=%b required 0 1 1",
                     bus.count, bus.sq_out, bus.running);
        end
        bus.enable = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            n_tests++;
            if (bus.count !== 16'(i % 5) || bus.tick !== ((i % 5) == 0) ||
                bus.sq_out !== ((i % 5) < 3)) begin
                n_fail++;
                $display("FAIL periodic cyc %0d: count=%0d tick=%b sq=%b required %0d %b %b",
                         i, bus.count, bus.tick, bus.sq_out, i % 5, (i % 5) == 0, (i % 5) < 3);
            end
        end
    endtask

    task automatic test_oneshot();
        do_load(16'd4);
        for (int rep = 0; rep < 2; rep++) begin
            do_start(1'b1);
            bus.enable = 1'b1;
            for (int i = 1; i <= 4; i++) begin
                step();
                n_tests++;
                if (bus.tick !== (i == 4) || bus.running !== (i != 4) || bus.count !== 16'(i % 4)) begin
                    n_fail++;
                    $display("FAIL oneshot rep %0d cyc %0d: tick=%b run=%b count=%0d required %b %b %0d",
                             rep, i, bus.tick, bus.running, bus.count, i == 4, i != 4, i % 4);
                end
            end
            for (int i = 0; i < 5; i++) begin
                step();
                n_tests++;
                if (bus.tick !== 1'b0 || bus.running !== 1'b0 || bus.count !== 16'd0 ||
                    bus.sq_out !== 1'b0) begin
                    n_fail++;
                    $display("FAIL oneshot_done rep %0d: tick=%b run=%b count=%0d sq=%b required 0 0 0 0",
                             rep, bus.tick, bus.running, bus.count, bus.sq_out);
                end
            end
        end
        n_tests++;
        if (bus.tick_count !== 8'd2) begin
            n_fail++;
            $display("FAIL oneshot_tcnt: got %0d required 2", bus.tick_count);
        end
    endtask

    task automatic test_enable_toggle();
        int k;
        do_load(16'd3);
        do_start(1'b0);
        k = 0;
        for (int i = 0; i < 12; i++) begin
            bus.enable = ((i % 2) == 0);
            if ((i % 2) == 0) k++;
            step();
            n_tests++;
            if (bus.count !== 16'(k % 3) || bus.tick !== (((i % 2) == 0) && ((k % 3) == 0))) begin
                n_fail++;
                $display("FAIL toggle step %0d: count=%0d tick=%b required %0d %b",
                         i, bus.count, bus.tick, k % 3, ((i % 2) == 0) && ((k % 3) == 0));
            end
        end
        bus.enable = 1'b1;
        step();
        do_load(16'd0);
        n_tests++;
        if (bus.count !== 16'd1 || bus.running !== 1'b1) begin
            n_fail++;
            $display("FAIL load_zero: count=%0d run=%b required 1 1", bus.count, bus.running);
        end
        bus.enable = 1'b1;
        step();
        step();
        n_tests++;
        if (bus.count !== 16'd0 || bus.tick !== 1'b1) begin
            n_fail++;
            $display("FAIL load_zero_mod: count=%0d tick=%b required 0 1", bus.count, bus.tick);
        end
    endtask

    task automatic test_midperiod();
        do_load(16'd10);
        do_start(1'b0);
        bus.enable = 1'b1;
        repeat (7) step();
        bus.load = 1'b1; bus.modulo_in = 16'd6;
        step();
        bus.load = 1'b0;
        n_tests++;
        if (bus.count !== 16'd0 || bus.tick_count !== 8'd0 || bus.running !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_load: count=%0d tcnt=%0d run=%b required 0 0 1",
                     bus.count, bus.tick_count, bus.running);
        end
        for (int i = 1; i <= 6; i++) begin
            step();
            n_tests++;
            if (bus.tick !== (i == 6)) begin
                n_fail++;
                $display("FAIL mid_load_tick cyc %0d: tick=%b required %b", i, bus.tick, i == 6);
            end
        end
        do_load(16'd10);
        do_start(1'b0);
        bus.enable = 1'b1;
        repeat (7) step();
        bus.start = 1'b1; bus.oneshot = 1'b0;
        step();
        bus.start = 1'b0;
        n_tests++;
        if (bus.count !== 16'd0 || bus.tick !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_start: count=%0d tick=%b required 0 0", bus.count, bus.tick);
        end
        for (int i = 1; i <= 10; i++) begin
            step();
            n_tests++;
            if (bus.tick !== (i == 10)) begin
                n_fail++;
                $display("FAIL mid_start_tick cyc %0d: tick=%b required %b", i, bus.tick, i == 10);
            end
        end
        repeat (7) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        bus.enable = 1'b0;
        n_tests++;
        if ({bus.count, bus.tick, bus.sq_out, bus.running, bus.tick_count} !== 27'd0) begin
            n_fail++;
            $display("FAIL mid_reset: count=%0d tick=%b sq=%b run=%b tcnt=%0d, all required 0",
                     bus.count, bus.tick, bus.sq_out, bus.running, bus.tick_count);
        end
        do_start(1'b0);
        bus.enable = 1'b1;
        for (int i = 1; i <= RST_MOD; i++) begin
            step();
            n_tests++;
            if (bus.tick !== (i == RST_MOD)) begin
                n_fail++;
                $display("FAIL reset_mod cyc %0d: tick=%b required %b", i, bus.tick, i == RST_MOD);
            end
        end
    endtask

    task automatic test_modulo_one_wrap();
        do_load(16'd1);
        do_start(1'b0);
        bus.enable = 1'b1;
        for (int i = 1; i <= 257; i++) begin
            step();
            n_tests++;
            if (bus.tick !== 1'b1 || bus.count !== 16'd0 || bus.sq_out !== 1'b1 ||
                bus.tick_count !== 8'(i)) begin
                n_fail++;
                $display("FAIL mod1 cyc %0d: tick=%b count=%0d sq=%b tcnt=%0d required 1 0 1 %0d",
                         i, bus.tick, bus.count, bus.sq_out, bus.tick_count, i % 256);
            end
        end
        n_tests++;
        if (bus.tick_count !== 8'd1) begin
            n_fail++;
            $display("FAIL mod1_wrap: tcnt=%0d required 1", bus.tick_count);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        bus.enable = 1'b0; bus.start = 1'b0; bus.oneshot = 1'b0;
        bus.load = 1'b0; bus.modulo_in = '0;
        #1;
        test_reset();
        test_default_modulo();
        test_periodic();
        test_oneshot();
        test_enable_toggle();
        test_midperiod();
        test_modulo_one_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/prog_modulo_counter.md
Name: prog_modulo_counter

Overview:
- Parametrised, run-time programmable successor to the fixed-modulo clock-divide counter.
- Divides `clock` by a loadable modulo and emits a one-cycle `tick` pulse per period.
- Adds start/one-shot control, a near-50% square-wave output and a wrapping tick-event counter.
- Serves as the timebase for display refresh, debounce and UART baud prescalers.

Parameters:
- BIT_SZ, 16: width of counter and modulo register.
- RESET_MODULO, 50000: modulo value after reset; must satisfy 1 <= RESET_MODULO <= 2^BIT_SZ-1.
- TICK_CNT_SZ, 8: width of the tick-event counter.

Ports:
- clock  input  1  system clock; all logic on its rising edge.
- sreset_n  input  1  synchronous active-low reset.
- enable  input  1  high = advance count this cycle.
- start  input  1  one-cycle pulse; begins or restarts a count sequence.
- oneshot  input  1  mode, sampled only when start is accepted; 1 = single period, 0 = periodic.
- load  input  1  one-cycle pulse; write modulo_in to the modulo register.
- modulo_in  input  BIT_SZ  new modulo value.
- tick  output  1  registered one-cycle pulse at end of each period.
- sq_out  output  1  registered square wave, period = modulo.
- running  output  1  high while in RUN state.
- count  output  BIT_SZ  current count value.
- tick_count  output  TICK_CNT_SZ  number of ticks emitted, wraps modulo 2^TICK_CNT_SZ.

Behaviour:
- Reset (sreset_n=0 at a clock edge):
  - state=IDLE, mod_r=RESET_MODULO, mode_r=0.
  - count=0, tick=0, sq_out=0, tick_count=0, running=0.
- Priority each cycle: reset > load > start > counting.
- States: IDLE, RUN, DONE. running = (state==RUN).
- start accepted in any state:
  - state<=RUN, count<=0, mode_r<=oneshot, tick<=0.
  - A start in RUN restarts the period.
- load (any state):
  - If modulo_in != 0: mod_r<=modulo_in, count<=0, tick<=0, tick_count<=0; state unchanged.
  - If modulo_in == 0: load is ignored entirely, with no state change.
  - start in the same cycle as load is ignored.
- RUN with enable=1:
  - If count == mod_r-1: count<=0, tick<=1. If mode_r=1, state<=DONE.
  - Otherwise: count<=count+1, tick<=0.
- RUN with enable=0: count holds, tick<=0. tick never stays high for more than one cycle.
- IDLE/DONE: count holds, tick<=0, sq_out<=0. enable has no effect.
- Tick latency: tick is high during the cycle after the edge at which count==mod_r-1 was sampled with enable=1. Period = mod_r enabled cycles.
- mod_r == 1: tick is high every enabled cycle in RUN; count stays 0.
- tick_count increments (wrapping) on each edge that sets tick<=1.
- sq_out in RUN: sq_out <= (count_next < ((mod_r+1)>>1)), where count_next is the value being written to count.
  - High for ceil(mod_r/2) cycles, low for floor(mod_r/2) cycles.
  - mod_r == 1 gives constant 1 while RUN.
  - Holds its value while enable=0.
- Arithmetic:
  - All compares are unsigned, BIT_SZ wide.
  - mod_r-1 never underflows, since mod_r >= 1 is guaranteed by the load rule.
  - (mod_r+1)>>1 is computed at BIT_SZ+1 bits.
- Reset mid-period overrides everything; no tick is emitted on the reset cycle.

Test Plan:
- Reset, then start (oneshot=0), enable=1 held, default modulo 50000 → tick pulses exactly every 50000 cycles, first pulse 50000 cycles after start; tick_count=3 after 150000 cycles.
- load modulo_in=5, start oneshot=0, enable=1 → count sequence 0,1,2,3,4,0; tick one cycle wide every 5 cycles; sq_out pattern 1,1,1,0,0 repeating.
- load 4, start oneshot=1, enable=1 → exactly one tick 4 cycles after start; running drops to 0 in the same cycle tick rises; count frozen at 0; further enable produces no tick. A second start repeats the sequence.
- modulo 3, toggle enable 1,0,1,0… → tick every 6 clocks, never high for two cycles; count holds on disabled cycles. load modulo_in=0 mid-run → mod_r stays 3, count unaffected.
- Mid-period checks (modulo 10, count=7):
  - Assert load with 6 → count=0, tick_count=0, next tick after 6 enabled cycles.
  - Assert start → count=0, restarts period.
  - Assert sreset_n=0 → all outputs 0, mod_r=50000, state IDLE.
- TICK_CNT_SZ=8, modulo 1, run 257 enabled cycles → tick high every cycle; tick_count wraps 255→0 and reads 1 after 257 ticks.
